// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART: DATA/STATUS/DIVISOR/CONTROL window with TX and RX FIFOs.
// Define UART_MMIO_LOOPBACK_EN to add the CONTROL loopback bit (internal tx -> rx).
module uart_mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int unsigned DIV_RESET  = 868,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] DIV_INIT = 16'(DIV_RESET);

    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
    localparam logic [1:0] OFF_DATA = 2'd0, OFF_STATUS = 2'd1, OFF_DIV = 2'd2, OFF_CTRL = 2'd3;

    logic [15:0]   r_div;
    logic          r_ovr, r_ferr, r_irq;
    logic [7:0]    r_txf [FIFO_DEPTH];
    logic [AW-1:0] r_txf_wp, r_txf_rp;
    logic [AW:0]   r_txf_cnt;
    logic [7:0]    r_rxf [FIFO_DEPTH];
    logic [AW-1:0] r_rxf_wp, r_rxf_rp;
    logic [AW:0]   r_rxf_cnt;
    logic [1:0]    r_tx_st, r_rx_st;
    logic [15:0]   r_tx_cyc, r_tx_len, r_rx_cyc, r_rx_len;
    logic [2:0]    r_tx_bit, r_rx_bit;
    logic [7:0]    r_tx_sh, r_rx_sh;
    logic          r_tx_out;
    logic          r_rx_s1, r_rx_s2, r_rx_s3;

    logic       w_hit, w_wr, w_rd, w_rx_in;
    logic [1:0] w_off;
    logic       w_txf_empty, w_txf_full, w_rxf_empty, w_rxf_full, w_tx_busy;
    logic       w_tx_bit_end, w_tx_pop, w_tx_push;
    logic       w_rx_bit_end, w_rx_half_end, w_rx_done, w_rx_good, w_rx_pop, w_rx_push;
    logic       w_ovr_set, w_ferr_set, w_stat_rd;
    logic       w_unused_bits;

    assign w_hit = (Address[31:4] == BASE_ADDR[31:4]);
    assign w_off = Address[3:2];
    assign w_wr  = MemWrite && w_hit;
    assign w_rd  = MemRead && w_hit;
    assign Hit   = w_hit;
    assign irq   = r_irq;
    assign w_unused_bits = &{1'b0, Address[1:0], WriteData[31:16]};

    assign w_txf_empty = (r_txf_cnt == '0);
    assign w_txf_full  = (r_txf_cnt == FULL_CNT);
    assign w_rxf_empty = (r_rxf_cnt == '0);
    assign w_rxf_full  = (r_rxf_cnt == FULL_CNT);
    assign w_tx_busy   = (r_tx_st != S_IDLE);

    assign w_tx_bit_end = (r_tx_cyc == r_tx_len - 16'd1);
    assign w_tx_pop  = !w_txf_empty && ((r_tx_st == S_IDLE) || (r_tx_st == S_STOP && w_tx_bit_end));
    assign w_tx_push = w_wr && (w_off == OFF_DATA) && (!w_txf_full || w_tx_pop);

    assign w_rx_bit_end  = (r_rx_cyc == r_rx_len - 16'd1);
    assign w_rx_half_end = (r_rx_cyc == {1'b0, r_rx_len[15:1]} - 16'd1);
    assign w_rx_done  = (r_rx_st == S_STOP) && w_rx_bit_end;
    assign w_rx_good  = w_rx_done && r_rx_s2;
    assign w_rx_pop   = w_rd && (w_off == OFF_DATA) && !w_rxf_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
    assign w_rx_push  = w_rx_good && (!w_rxf_full || w_rx_pop);
    assign w_ovr_set  = w_rx_good && w_rxf_full && !w_rx_pop;
    assign w_ferr_set = w_rx_done && !r_rx_s2;
    assign w_stat_rd  = w_rd && (w_off == OFF_STATUS);

`ifdef UART_MMIO_LOOPBACK_EN
    logic r_ctrl;
    assign tx      = r_ctrl ? 1'b1 : r_tx_out;
    assign w_rx_in = r_ctrl ? r_tx_out : rx;
`else
    assign tx      = r_tx_out;
    assign w_rx_in = rx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= DIV_INIT;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
            r_irq  <= 1'b0;
`ifdef UART_MMIO_LOOPBACK_EN
            r_ctrl <= 1'b0;
`endif
        end else begin
            if (w_wr && w_off == OFF_DIV)
                r_div <= (WriteData[15:0] < 16'd2) ? 16'd2 : WriteData[15:0];
`ifdef UART_MMIO_LOOPBACK_EN
            if (w_wr && w_off == OFF_CTRL)
                r_ctrl <= WriteData[0];
`endif
            r_ovr  <= w_ovr_set || (r_ovr && !w_stat_rd);
            r_ferr <= w_ferr_set || (r_ferr && !w_stat_rd);
            r_irq  <= !w_rxf_empty || r_ovr || r_ferr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txf_wp <= '0; r_txf_rp <= '0; r_txf_cnt <= '0;
            r_rxf_wp <= '0; r_rxf_rp <= '0; r_rxf_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_txf[r_txf_wp] <= WriteData[7:0];
                r_txf_wp <= r_txf_wp + 1'b1;
            end
            if (w_tx_pop) r_txf_rp <= r_txf_rp + 1'b1;
            if (w_tx_push && !w_tx_pop) r_txf_cnt <= r_txf_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_txf_cnt <= r_txf_cnt - 1'b1;

            if (w_rx_push) begin
                r_rxf[r_rxf_wp] <= r_rx_sh;
                r_rxf_wp <= r_rxf_wp + 1'b1;
            end
            if (w_rx_pop) r_rxf_rp <= r_rxf_rp + 1'b1;
            if (w_rx_push && !w_rx_pop) r_rxf_cnt <= r_rxf_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rxf_cnt <= r_rxf_cnt - 1'b1;
        end
    end

    // Bit length is latched at each start bit so divisor writes never disturb a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_st <= S_IDLE; r_tx_cyc <= '0; r_tx_len <= DIV_INIT;
            r_tx_bit <= '0; r_tx_sh <= '0; r_tx_out <= 1'b1;
        end else begin
            case (r_tx_st)
                S_IDLE: if (w_tx_pop) begin
                    r_tx_st <= S_START; r_tx_sh <= r_txf[r_txf_rp];
                    r_tx_len <= r_div; r_tx_cyc <= '0; r_tx_out <= 1'b0;
                end
                S_START: if (w_tx_bit_end) begin
                    r_tx_st <= S_DATA; r_tx_cyc <= '0; r_tx_bit <= '0;
                    r_tx_out <= r_tx_sh[0]; r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                end else r_tx_cyc <= r_tx_cyc + 16'd1;
                S_DATA: if (w_tx_bit_end) begin
                    r_tx_cyc <= '0;
                    if (r_tx_bit == 3'd7) begin
                        r_tx_st <= S_STOP; r_tx_out <= 1'b1;
                    end else begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                        r_tx_out <= r_tx_sh[0]; r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                    end
                end else r_tx_cyc <= r_tx_cyc + 16'd1;
                S_STOP: if (w_tx_bit_end) begin
                    r_tx_cyc <= '0;
                    if (w_tx_pop) begin
                        r_tx_st <= S_START; r_tx_sh <= r_txf[r_txf_rp];
                        r_tx_len <= r_div; r_tx_out <= 1'b0;
                    end else begin
                        r_tx_st <= S_IDLE; r_tx_out <= 1'b1;
                    end
                end else r_tx_cyc <= r_tx_cyc + 16'd1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_s3 <= 1'b1;
            r_rx_st <= S_IDLE; r_rx_cyc <= '0; r_rx_len <= DIV_INIT;
            r_rx_bit <= '0; r_rx_sh <= '0;
        end else begin
            r_rx_s1 <= w_rx_in; r_rx_s2 <= r_rx_s1; r_rx_s3 <= r_rx_s2;
            case (r_rx_st)
                S_IDLE: if (r_rx_s3 && !r_rx_s2) begin
                    r_rx_st <= S_START; r_rx_cyc <= '0; r_rx_len <= r_div;
                end
                S_START: if (w_rx_half_end) begin
                    r_rx_cyc <= '0; r_rx_bit <= '0;
                    r_rx_st <= r_rx_s2 ? S_IDLE : S_DATA;
                end else r_rx_cyc <= r_rx_cyc + 16'd1;
                S_DATA: if (w_rx_bit_end) begin
                    r_rx_cyc <= '0;
                    r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
                    if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
                    else r_rx_bit <= r_rx_bit + 3'd1;
                end else r_rx_cyc <= r_rx_cyc + 16'd1;
                S_STOP: if (w_rx_bit_end) begin
                    r_rx_cyc <= '0; r_rx_st <= S_IDLE;
                end else r_rx_cyc <= r_rx_cyc + 16'd1;
            endcase
        end
    end

    always_comb begin
        ReadData = '0;
        if (w_hit) begin
            case (w_off)
                OFF_DATA:   if (!w_rxf_empty) ReadData[7:0] = r_rxf[r_rxf_rp];
                OFF_STATUS: ReadData[5:0] = {r_ferr, w_tx_busy, r_ovr, w_rxf_empty, w_txf_empty, w_txf_full};
                OFF_DIV:    ReadData[15:0] = r_div;
                OFF_CTRL: begin
`ifdef UART_MMIO_LOOPBACK_EN
                    ReadData[0] = r_ctrl;
`endif
                end
            endcase
        end
    end
endmodule
